// File: rtl/rr_arbiter_n_if.sv
// ---------------------------------------------------------------------------
// rr_arbiter_n_if -- request/grant bundle for the round-robin arbiter.
//
// Parameter
//   N        number of requesters
// Signals
//   rr_in    [N-1:0]   request vector, bit i = requester i wants the resource
//   rr_out   [N-1:0]   one-hot grant vector, zero when idle
//   rr_idx   [IW-1:0]  binary index of the granted requester, 0 when idle
//   rr_valid           1 while a grant is held
// Modports
//   master   requester side: drives rr_in, observes the grant
//   slave    arbiter side: observes rr_in, drives the grant
// ---------------------------------------------------------------------------
interface rr_arbiter_n_if #(
    parameter int N = 4
);
    localparam int IW = $clog2(N);

    logic [N-1:0]  rr_in;
    logic [N-1:0]  rr_out;
    logic [IW-1:0] rr_idx;
    logic          rr_valid;

    modport master (
        output rr_in,
        input  rr_out,
        input  rr_idx,
        input  rr_valid
    );

    modport slave (
        input  rr_in,
        output rr_out,
        output rr_idx,
        output rr_valid
    );
endinterface

// File: rtl/rr_arbiter_n.sv
// ---------------------------------------------------------------------------
// rr_arbiter_n -- N-way round-robin arbiter with registered grant outputs.
//
// A holder keeps the grant as long as its request stays high. When the
// holder releases (or nobody holds), the next winner is the first set
// request bit found searching upward from ptr, wrapping N-1 -> 0. ptr is
// always (last winner + 1) mod N, and is left untouched while idle.
//
// Optional feature (macro RR_HOLD_LIMIT_EN): a hold counter limits a holder
// to MAX_HOLD consecutive cycles whenever another requester is waiting. A
// sole requester at the limit keeps the grant without a gap.
//
// Parameters
//   N         number of requesters (2..32)
//   MAX_HOLD  max consecutive grant cycles with the hold limit (1..255)
// Ports
//   clk       rising-edge clock
//   rst_in    synchronous active-high reset
//   bus       rr_arbiter_n_if.slave: rr_in in; rr_out/rr_idx/rr_valid out
// ---------------------------------------------------------------------------
module rr_arbiter_n #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 4
) (
    input  logic            clk,
    input  logic            rst_in,
    rr_arbiter_n_if.slave   bus
);
    localparam int IW = $clog2(N);
    localparam logic [N-1:0] ONE_HOT_LSB = {{(N-1){1'b0}}, 1'b1};

    if (N < 2 || N > 32 || MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_param
        $error("rr_arbiter_n: parameter out of range");
    end

    // (base + off) mod N for off in 0..N-1
    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= N) begin
            sum = sum - N;
        end else begin
            sum = sum;
        end
        return IW'(sum);
    endfunction

    // (idx + 1) mod N, correct also for non-power-of-two N
    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] idx);
        if (idx == IW'(N - 1)) begin
            return {IW{1'b0}};
        end else begin
            return idx + IW'(1);
        end
    endfunction

    logic [N-1:0]  gnt_r;
    logic [IW-1:0] idx_r;
    logic          valid_r;
    logic [IW-1:0] ptr_r;

    logic          holder_req_s;
    logic          rotate_due_s;
    logic [N-1:0]  search_mask_s;
    logic          found_s;
    logic [IW-1:0] winner_s;

    // gnt_r is zero while idle, so this is also false when nobody holds
    assign holder_req_s = |(bus.rr_in & gnt_r);

`ifdef RR_HOLD_LIMIT_EN
    localparam int CW = $clog2(MAX_HOLD + 1);

    logic [CW-1:0] hold_cnt_r;
    logic [N-1:0]  others_s;

    assign others_s     = bus.rr_in & ~gnt_r;
    assign rotate_due_s = holder_req_s && (hold_cnt_r == CW'(MAX_HOLD)) && (|others_s);
    // a forced rotation excludes the holder from this one arbitration
    assign search_mask_s = rotate_due_s ? others_s : bus.rr_in;

    // Hold counter: consecutive cycles of the current grant, restarting at 1
    always_ff @(posedge clk) begin
        if (rst_in) begin
            hold_cnt_r <= {CW{1'b0}};
        end else if (bus.rr_in == {N{1'b0}}) begin
            hold_cnt_r <= {CW{1'b0}};
        end else if (holder_req_s && !rotate_due_s) begin
            // sole requester at the limit keeps the grant; count starts over
            if (hold_cnt_r == CW'(MAX_HOLD)) begin
                hold_cnt_r <= CW'(1);
            end else begin
                hold_cnt_r <= hold_cnt_r + CW'(1);
            end
        end else begin
            hold_cnt_r <= CW'(1);
        end
    end
`else
    assign rotate_due_s  = 1'b0;
    assign search_mask_s = bus.rr_in;
`endif

    // Priority search: first set bit upward from ptr, wrapping at N-1
    always_comb begin
        found_s  = 1'b0;
        winner_s = {IW{1'b0}};
        for (int k = 0; k < N; k++) begin
            if (!found_s && search_mask_s[wrap_add(ptr_r, k)]) begin
                found_s  = 1'b1;
                winner_s = wrap_add(ptr_r, k);
            end else begin
                found_s  = found_s;
            end
        end
    end

    // Grant and pointer registers
    always_ff @(posedge clk) begin
        if (rst_in) begin
            gnt_r   <= {N{1'b0}};
            idx_r   <= {IW{1'b0}};
            valid_r <= 1'b0;
            ptr_r   <= {IW{1'b0}};
        end else if (bus.rr_in == {N{1'b0}}) begin
            gnt_r   <= {N{1'b0}};
            idx_r   <= {IW{1'b0}};
            valid_r <= 1'b0;
        end else if (holder_req_s && !rotate_due_s) begin
            gnt_r   <= gnt_r;
            idx_r   <= idx_r;
            valid_r <= 1'b1;
        end else if (found_s) begin
            // the grant register is replaced wholesale, so old and new never overlap
            gnt_r   <= ONE_HOT_LSB << winner_s;
            idx_r   <= winner_s;
            valid_r <= 1'b1;
            ptr_r   <= next_idx(winner_s);
        end else begin
            gnt_r   <= {N{1'b0}};
            idx_r   <= {IW{1'b0}};
            valid_r <= 1'b0;
        end
    end

    assign bus.rr_out   = gnt_r;
    assign bus.rr_idx   = idx_r;
    assign bus.rr_valid = valid_r;
endmodule

// File: tb/tb_rr_arbiter_n.sv
// ---------------------------------------------------------------------------
// tb_rr_arbiter_n -- directed self-checking bench for rr_arbiter_n
// (N=4, MAX_HOLD=4). Builds with or without RR_HOLD_LIMIT_EN; the
// hold-limit expectations follow the macro.
// ---------------------------------------------------------------------------
module tb_rr_arbiter_n;
    logic clk;
    logic rst_in;
    int   n_cmp;
    int   n_bad;

    rr_arbiter_n_if #(.N(4)) bus ();

    rr_arbiter_n #(.N(4), .MAX_HOLD(4)) dut (
        .clk    (clk),
        .rst_in (rst_in),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // advance one edge, then sample away from it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_grant(input string tag, input int out_e, input int idx_e, input int vld_e);
        check_eq({tag, ".out"}, int'(bus.rr_out), out_e);
        check_eq({tag, ".idx"}, int'(bus.rr_idx), idx_e);
        check_eq({tag, ".vld"}, int'(bus.rr_valid), vld_e);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;

        // reset dominates a full request vector
        rst_in = 1'b1;
        bus.rr_in = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_grant("reset", 0, 0, 0);
        end

        // release sequence, then the holder releases so the wrapped ptr decides
        bus.rr_in = 4'b1011;
        rst_in = 1'b0;
        tick(); check_grant("rel0", 4'b0001, 0, 1);
        bus.rr_in = 4'b1010;
        tick(); check_grant("rel1", 4'b0010, 1, 1);
        bus.rr_in = 4'b1000;
        tick(); check_grant("rel2", 4'b1000, 3, 1);
        bus.rr_in = 4'b1111;
        tick(); check_grant("keep3", 4'b1000, 3, 1);
        bus.rr_in = 4'b0111;
        tick(); check_grant("wrap", 4'b0001, 0, 1);

        // full contention from reset
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        bus.rr_in = 4'b1111;
`ifdef RR_HOLD_LIMIT_EN
        for (int c = 0; c < 17; c++) begin
            tick();
            check_eq("rot", int'(bus.rr_out), 1 << ((c / 4) % 4));
        end
`else
        for (int c = 0; c < 20; c++) begin
            tick();
            check_eq("hold", int'(bus.rr_out), 4'b0001);
        end
`endif

        // sole requester never sees a gap
        bus.rr_in = 4'b0100;
        tick(); check_grant("sole0", 4'b0100, 2, 1);
        for (int c = 1; c < 12; c++) begin
            tick();
            check_grant("sole", 4'b0100, 2, 1);
        end

        // reset mid-grant discards the holder, search restarts at 0
        rst_in = 1'b1;
        bus.rr_in = 4'b1111;
        tick(); check_grant("rstmid", 0, 0, 0);
        rst_in = 1'b0;
        tick(); check_grant("post_rst", 4'b0001, 0, 1);
        bus.rr_in = 4'b0000;
        tick(); check_grant("idle", 0, 0, 0);

        // ptr (=1) survives idle: 0011 must pick index 1, not 0
        bus.rr_in = 4'b0011;
        tick(); check_grant("ptr_kept", 4'b0010, 1, 1);

        bus.rr_in = 4'b0000;
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
